// File: rtl/my_mem_parity_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_mem_parity_ctrl_if
//  Description : Access/result bundle for the parity-checked memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_mem_parity_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              inj_err;
    logic              clr_count;
    logic [DATA_W:0]   data_out;
    logic              rd_valid;
    logic              parity_err;
    logic              unwritten_err;
    logic              rw_conflict;
    logic [CNT_W-1:0]  error_count;

    modport master (
        output write, read, address, data_in, inj_err, clr_count,
        input  data_out, rd_valid, parity_err, unwritten_err, rw_conflict, error_count
    );

    modport slave (
        input  write, read, address, data_in, inj_err, clr_count,
        output data_out, rd_valid, parity_err, unwritten_err, rw_conflict, error_count
    );
endinterface
`default_nettype wire

// File: rtl/my_mem_parity_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : my_mem_parity_ctrl
//  Description : Single-port RAM with per-word parity, written-word tracking,
//                collision detection and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_mem_parity_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    my_mem_parity_ctrl_if.slave    bus
);

    localparam int   c_depth = 2 ** ADDR_W;
    localparam logic c_odd   = (ODD_PARITY != 0);

    logic [DATA_W:0]    r_mem [c_depth];
    logic [c_depth-1:0] r_written;

    logic [DATA_W:0]    r_data_out;
    logic               r_rd_valid;
    logic               r_parity_err;
    logic               r_unwritten_err;
    logic               r_rw_conflict;
    logic [CNT_W-1:0]   r_error_count;

    logic               w_do_write;
    logic               w_do_read;
    logic               w_conflict;
    logic [DATA_W:0]    w_rd_word;
    logic               w_hit;
    logic               w_par_bad;
    logic               w_wr_par;
    logic               w_err_event;

    assign w_do_write  = bus.write & ~bus.read;
    assign w_do_read   = bus.read & ~bus.write;
    assign w_conflict  = bus.write & bus.read;
    assign w_rd_word   = r_mem[bus.address];
    assign w_hit       = r_written[bus.address];
    assign w_par_bad   = ((^w_rd_word[DATA_W-1:0]) ^ c_odd) != w_rd_word[DATA_W];
    assign w_wr_par    = (^bus.data_in) ^ c_odd ^ bus.inj_err;
    // A never-written word always counts as an error; a written one only on mismatch.
    assign w_err_event = (w_do_read & (w_hit ? w_par_bad : 1'b1)) | w_conflict;

    // Storage is deliberately not reset; the written flags gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[bus.address] <= {w_wr_par, bus.data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written       <= '0;
            r_data_out      <= '0;
            r_rd_valid      <= 1'b0;
            r_parity_err    <= 1'b0;
            r_unwritten_err <= 1'b0;
            r_rw_conflict   <= 1'b0;
            r_error_count   <= '0;
        end else begin
            r_rd_valid      <= w_do_read;
            r_parity_err    <= w_do_read & w_hit & w_par_bad;
            r_unwritten_err <= w_do_read & ~w_hit;
            r_rw_conflict   <= w_conflict;

            if (w_do_write) begin
                r_written[bus.address] <= 1'b1;
            end
            if (w_do_read) begin
                r_data_out <= w_hit ? w_rd_word : '0;
            end

            // Count lands together with the pulse it accounts for.
            if (bus.clr_count) begin
                r_error_count <= '0;
            end else if (w_err_event && (r_error_count != {CNT_W{1'b1}})) begin
                r_error_count <= r_error_count + CNT_W'(1);
            end
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.parity_err    = r_parity_err;
    assign bus.unwritten_err = r_unwritten_err;
    assign bus.rw_conflict   = r_rw_conflict;
    assign bus.error_count   = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_my_mem_parity_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_mem_parity_ctrl
//  Description : Directed self-checking bench: default, 2-bit counter and
//                odd-parity instances driven by one shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_mem_parity_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_write = 1'b0, s_read = 1'b0, s_inj = 1'b0, s_clr = 1'b0;
    logic [7:0] s_addr = '0, s_data = '0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    my_mem_parity_ctrl_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) bus_d ();
    my_mem_parity_ctrl_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) bus_c ();
    my_mem_parity_ctrl_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) bus_o ();

    assign bus_d.write = s_write;  assign bus_c.write = s_write;  assign bus_o.write = s_write;
    assign bus_d.read  = s_read;   assign bus_c.read  = s_read;   assign bus_o.read  = s_read;
    assign bus_d.address = s_addr; assign bus_c.address = s_addr; assign bus_o.address = s_addr;
    assign bus_d.data_in = s_data; assign bus_c.data_in = s_data; assign bus_o.data_in = s_data;
    assign bus_d.inj_err = s_inj;  assign bus_c.inj_err = s_inj;  assign bus_o.inj_err = s_inj;
    assign bus_d.clr_count = s_clr; assign bus_c.clr_count = s_clr; assign bus_o.clr_count = s_clr;

    my_mem_parity_ctrl #(.DATA_W(8), .ADDR_W(8), .ODD_PARITY(0), .CNT_W(8))
        dut   (.clk(clk), .rst_n(rst_n), .bus(bus_d));
    my_mem_parity_ctrl #(.DATA_W(8), .ADDR_W(8), .ODD_PARITY(0), .CNT_W(2))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
    my_mem_parity_ctrl #(.DATA_W(8), .ADDR_W(8), .ODD_PARITY(1), .CNT_W(8))
        dut_o (.clk(clk), .rst_n(rst_n), .bus(bus_o));

    // Drive on the falling edge, observe just after the next rising edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] a,
                       input logic [7:0] d, input logic inj, input logic clr);
        @(negedge clk);
        s_write = w; s_read = r; s_addr = a; s_data = d; s_inj = inj; s_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_write = 0; s_read = 0; s_inj = 0; s_clr = 0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus_d.data_out !== 9'h000) begin failures++; $display("FAIL reset_data_out got=%h exp=000", bus_d.data_out); end
        checks++; if ({bus_d.rd_valid, bus_d.parity_err, bus_d.unwritten_err, bus_d.rw_conflict} !== 4'b0000)
            begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {bus_d.rd_valid, bus_d.parity_err, bus_d.unwritten_err, bus_d.rw_conflict}); end
        checks++; if (bus_d.error_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus_d.error_count); end
    endtask

    task automatic test_defaults();
        do_reset();
        cyc(1, 0, 8'h12, 8'hA5, 0, 0);
        checks++; if (bus_d.rd_valid !== 1'b0) begin failures++; $display("FAIL write_no_valid got=%b exp=0", bus_d.rd_valid); end
        cyc(0, 1, 8'h12, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h0A5) begin failures++; $display("FAIL rd12_data got=%h exp=0a5", bus_d.data_out); end
        checks++; if ({bus_d.rd_valid, bus_d.parity_err, bus_d.unwritten_err} !== 3'b100)
            begin failures++; $display("FAIL rd12_flags got=%b exp=100", {bus_d.rd_valid, bus_d.parity_err, bus_d.unwritten_err}); end
        checks++; if (bus_d.error_count !== 8'd0) begin failures++; $display("FAIL rd12_count got=%0d exp=0", bus_d.error_count); end
        cyc(0, 0, 8'h00, 8'h00, 0, 0);
        checks++; if (bus_d.rd_valid !== 1'b0) begin failures++; $display("FAIL valid_one_cycle got=%b exp=0", bus_d.rd_valid); end
        checks++; if (bus_d.data_out !== 9'h0A5) begin failures++; $display("FAIL data_hold got=%h exp=0a5", bus_d.data_out); end
        cyc(1, 0, 8'h13, 8'h07, 0, 0);
        cyc(0, 1, 8'h13, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h107) begin failures++; $display("FAIL rd13_data got=%h exp=107", bus_d.data_out); end
    endtask

    task automatic test_inject();
        do_reset();
        cyc(1, 0, 8'h20, 8'h3C, 1, 0);
        cyc(0, 1, 8'h20, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h13C) begin failures++; $display("FAIL inj_data got=%h exp=13c", bus_d.data_out); end
        checks++; if (bus_d.parity_err !== 1'b1) begin failures++; $display("FAIL inj_perr got=%b exp=1", bus_d.parity_err); end
        checks++; if (bus_d.error_count !== 8'd1) begin failures++; $display("FAIL inj_count got=%0d exp=1", bus_d.error_count); end
        cyc(1, 0, 8'h20, 8'h3C, 0, 0);
        cyc(0, 1, 8'h20, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h03C) begin failures++; $display("FAIL clean_data got=%h exp=03c", bus_d.data_out); end
        checks++; if (bus_d.parity_err !== 1'b0) begin failures++; $display("FAIL clean_perr got=%b exp=0", bus_d.parity_err); end
    endtask

    task automatic test_unwritten();
        do_reset();
        cyc(0, 1, 8'h55, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h000) begin failures++; $display("FAIL unw_data got=%h exp=000", bus_d.data_out); end
        checks++; if ({bus_d.rd_valid, bus_d.unwritten_err, bus_d.parity_err} !== 3'b110)
            begin failures++; $display("FAIL unw_flags got=%b exp=110", {bus_d.rd_valid, bus_d.unwritten_err, bus_d.parity_err}); end
        checks++; if (bus_d.error_count !== 8'd1) begin failures++; $display("FAIL unw_count got=%0d exp=1", bus_d.error_count); end
        cyc(1, 0, 8'h12, 8'hA5, 0, 0);
        // Read in flight when reset hits: it must vanish without a pulse.
        @(negedge clk);
        s_write = 0; s_read = 1; s_addr = 8'h12;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus_d.rd_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", bus_d.rd_valid); end
        @(negedge clk);
        s_read = 0; rst_n = 1'b1;
        cyc(0, 1, 8'h12, 8'h00, 0, 0);
        checks++; if (bus_d.unwritten_err !== 1'b1) begin failures++; $display("FAIL post_rst_unw got=%b exp=1", bus_d.unwritten_err); end
        checks++; if (bus_d.data_out !== 9'h000) begin failures++; $display("FAIL post_rst_data got=%h exp=000", bus_d.data_out); end
    endtask

    task automatic test_collision();
        do_reset();
        cyc(1, 0, 8'h12, 8'hA5, 0, 0);
        cyc(1, 1, 8'h12, 8'hFF, 0, 0);
        checks++; if ({bus_d.rw_conflict, bus_d.rd_valid} !== 2'b10)
            begin failures++; $display("FAIL coll_flags got=%b exp=10", {bus_d.rw_conflict, bus_d.rd_valid}); end
        checks++; if (bus_d.error_count !== 8'd1) begin failures++; $display("FAIL coll_count got=%0d exp=1", bus_d.error_count); end
        cyc(0, 1, 8'h12, 8'h00, 0, 0);
        checks++; if (bus_d.rw_conflict !== 1'b0) begin failures++; $display("FAIL coll_pulse got=%b exp=0", bus_d.rw_conflict); end
        checks++; if (bus_d.data_out !== 9'h0A5) begin failures++; $display("FAIL coll_keep got=%h exp=0a5", bus_d.data_out); end
        checks++; if (bus_d.error_count !== 8'd1) begin failures++; $display("FAIL coll_count2 got=%0d exp=1", bus_d.error_count); end
    endtask

    task automatic test_counter();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'hE0, 8'h00, 0, 0);
            checks++; if (bus_c.error_count !== exp_cnt[i])
                begin failures++; $display("FAIL sat_count%0d got=%0d exp=%0d", i, bus_c.error_count, exp_cnt[i]); end
        end
        cyc(0, 0, 8'h00, 8'h00, 0, 0);
        checks++; if (bus_c.error_count !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", bus_c.error_count); end
        cyc(0, 1, 8'hE0, 8'h00, 0, 1);
        checks++; if (bus_c.error_count !== 2'd0) begin failures++; $display("FAIL clr_prio got=%0d exp=0", bus_c.error_count); end
        checks++; if (bus_c.unwritten_err !== 1'b1) begin failures++; $display("FAIL clr_unw got=%b exp=1", bus_c.unwritten_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1, 0, 8'h40, 8'h5A, 0, 0);
        cyc(0, 1, 8'h40, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h05A) begin failures++; $display("FAIL wr_rd1 got=%h exp=05a", bus_d.data_out); end
        cyc(1, 0, 8'h40, 8'h01, 0, 0);
        cyc(0, 1, 8'h40, 8'h00, 0, 0);
        checks++; if (bus_d.data_out !== 9'h101) begin failures++; $display("FAIL wr_rd2 got=%h exp=101", bus_d.data_out); end
    endtask

    task automatic test_odd_parity();
        do_reset();
        cyc(1, 0, 8'h30, 8'hA5, 0, 0);
        cyc(1, 0, 8'h31, 8'h07, 0, 0);
        cyc(0, 1, 8'h30, 8'h00, 0, 0);
        checks++; if ({bus_o.rd_valid, bus_o.data_out} !== {1'b1, 9'h1A5})
            begin failures++; $display("FAIL odd_a5 got=%b_%h exp=1_1a5", bus_o.rd_valid, bus_o.data_out); end
        cyc(0, 1, 8'h31, 8'h00, 0, 0);
        checks++; if ({bus_o.rd_valid, bus_o.data_out} !== {1'b1, 9'h007})
            begin failures++; $display("FAIL odd_07 got=%b_%h exp=1_007", bus_o.rd_valid, bus_o.data_out); end
        checks++; if ({bus_o.parity_err, bus_o.error_count} !== {1'b0, 8'd0})
            begin failures++; $display("FAIL odd_noerr got=%b_%0d exp=0_0", bus_o.parity_err, bus_o.error_count); end
        cyc(0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_inject();
        test_unwritten();
        test_collision();
        test_counter();
        test_back_to_back();
        test_odd_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/my_mem_parity_ctrl.md
Name: my_mem_parity_ctrl

Overview:
Parametrised successor of the 8-bit parity memory: a single-port synchronous RAM of 2**ADDR_W words that stores DATA_W data bits plus one generated parity bit. Every read returns the stored parity and checks it. The block adds:
- even or odd parity mode
- write-side error injection for self-test
- tracking of never-written words
- read/write collision detection
- a saturating, clearable error counter in hardware

It is the memory under test for the my_mem_interface benches and later sits behind a bus front-end.

Parameters:
DATA_W, 8, data bits per word; stored word is DATA_W+1 bits.
ADDR_W, 8, address bits; DEPTH = 2**ADDR_W.
ODD_PARITY, 0, 0: p = ^data (even); 1: p = ~^data (odd).
CNT_W, 8, width of error_count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
write  input  1  write strobe, sampled on posedge clk
read  input  1  read strobe, sampled on posedge clk
address  input  ADDR_W  word address for read or write
data_in  input  DATA_W  write data
inj_err  input  1  with write: store inverted parity bit
clr_count  input  1  synchronous clear of error_count
data_out  output  DATA_W+1  {parity, data} of last read, registered
rd_valid  output  1  one-cycle pulse: data_out updated
parity_err  output  1  one-cycle pulse with rd_valid: stored parity mismatch
unwritten_err  output  1  one-cycle pulse with rd_valid: word never written since reset
rw_conflict  output  1  one-cycle pulse: read and write sampled together
error_count  output  CNT_W  saturating count of error events

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_out=0, rd_valid=0, parity_err=0, unwritten_err=0, rw_conflict=0, error_count=0.
  - All DEPTH written-flags clear.
  - RAM contents are not reset, but are unreachable until rewritten.
  - Reset mid-access aborts that access with no pulse.
- Write (write=1, read=0 at posedge):
  - mem[address] <= {p ^ inj_err, data_in}, where p follows ODD_PARITY.
  - written[address] <= 1.
  - No output changes.
- Read (read=1, write=0 at posedge): one-cycle latency.
  - At the next posedge, rd_valid=1 for exactly one cycle.
  - If written[address]=1: data_out = stored word. parity_err=1 iff the recomputed parity of the stored data differs from the stored parity bit.
  - If written[address]=0: data_out = 0, unwritten_err=1, parity_err=0.
  - data_out holds its value until the next read completes.
- Back-to-back access:
  - Reads every cycle give one result per cycle.
  - A write followed by a read of the same address in the next cycle returns the new data; there is no forwarding hazard.
- Collision (read=1 and write=1 at the same posedge):
  - Neither access is performed; RAM and written-flags are unchanged.
  - rw_conflict=1 for one cycle; rd_valid stays 0.
- Error counter:
  - Increments by exactly 1 in a cycle where any of parity_err, unwritten_err or rw_conflict is asserted.
  - Saturates at 2**CNT_W-1; never wraps.
  - clr_count=1 sets it to 0 and has priority over a same-cycle increment.
- Idle (read=0, write=0): all pulse outputs 0; state holds.
- Address decode is full: every value from 0 to DEPTH-1 is valid, so there is no out-of-range case.

Test Plan:
1. Defaults: reset, write A=0x12 D=0xA5, read 0x12 -> one cycle later data_out=0x0A5, rd_valid=1 for 1 cycle, no error pulses, error_count=0. Then write 0x07 at 0x13 and read it -> data_out=0x107.
2. Error injection: write A=0x20 D=0x3C with inj_err=1, read 0x20 -> data_out=0x13C, parity_err=1, error_count=1. Rewrite without injection and read -> data_out=0x03C, parity_err=0.
3. Unwritten read: after reset, read 0x55 -> data_out=0x000, unwritten_err=1, parity_err=0, error_count=1. Assert rst_n low mid-sequence, then read 0x12 -> unwritten_err=1.
4. Collision: preload 0x12=0xA5, then drive write=read=1 at A=0x12 with D=0xFF -> rw_conflict 1 cycle, rd_valid=0, error_count+1. A subsequent read of 0x12 -> 0x0A5.
5. Counter: with CNT_W=2, five error events -> error_count=3, held. Assert clr_count in the same cycle as an error -> error_count=0.
6. Odd parity: with ODD_PARITY=1, write 0xA5 -> read returns 0x1A5. Write 0x07 -> read returns 0x007. Back-to-back reads of both on consecutive cycles -> two consecutive rd_valid pulses with correct data.
